uart_tx_framer: RTL and testbench

Parametrised UART transmit framer. Accepts one data word per valid/ready handshake and serialises a complete frame on `tx`, one bit per `baud_clk` cycle:

- start bit;
- 5..MAX_DATA_W data bits, LSB first;
- optional parity bit;
- 1 or 2 stop bits.

It sits between the TX FIFO/register interface and the pad. It replaces the fixed 11-bit shift register with per-frame runtime format control and a one-entry holding buffer that allows gap-free back-to-back frames.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_holdbuf.sv | 56 +++++
 rtl/uart_tx_framer.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int unsigned MIN_DATA_W     = 5;
    localparam int unsigned MAX_FRAME_BITS = 13;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Clamp a requested data length into MIN_DATA_W..max_w.
    function automatic logic [3:0] clamp_len(input logic [3:0] dl, input int unsigned max_w);
        if (32'(dl) < MIN_DATA_W) return 4'(MIN_DATA_W);
        if (32'(dl) > max_w)      return 4'(max_w);
        return dl;
    endfunction

endpackage

// File: rtl/uart_tx_holdbuf.sv
// One-entry holding register between the valid/ready handshake and the framer.
module uart_tx_holdbuf #(
    parameter int unsigned W = 9
) (
    input  logic         baud_clk,
    input  logic         rst_n,
    input  logic [W-1:0] data,
    input  logic [3:0]   len,
    input  logic [2:0]   mode,
    input  logic         two_stop,
    input  logic         valid,
    input  logic         take,
    output logic         ready,
    output logic         full,
    output logic [W-1:0] held_data,
    output logic [3:0]   held_len,
    output logic [2:0]   held_mode,
    output logic         held_two_stop
);

    logic push;
    logic full_nxt;

    assign ready = ~full;
    assign push  = valid & ready;

    // A push while empty that is taken on the same edge bypasses the register,
    // so the entry only becomes occupied when nobody consumes it immediately.
    always_comb begin
        full_nxt = full;
        if (push)
            full_nxt = ~(take & ~full);
        else if (take)
            full_nxt = 1'b0;
    end

    // Occupancy flag and stored word/format.
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            full          <= 1'b0;
            held_data     <= '0;
            held_len      <= '0;
            held_mode     <= '0;
            held_two_stop <= 1'b0;
        end else begin
            full <= full_nxt;
            if (push) begin
                held_data     <= data;
                held_len      <= len;
                held_mode     <= mode;
                held_two_stop <= two_stop;
            end
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 5..MAX_DATA_W data bits LSB first, optional
// parity, 1 or 2 stop bits, one bit per baud_clk, with gap-free back-to-back.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int unsigned MAX_DATA_W = 9
) (
    input  logic                  baud_clk,
    input  logic                  rst_n,
    input  logic [MAX_DATA_W-1:0] tx_data,
    input  logic [3:0]            data_len,
    input  logic [2:0]            parity_mode,
    input  logic                  two_stop,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CNT_W = $clog2(MAX_DATA_W + 1);

    logic                  buf_full;
    logic [MAX_DATA_W-1:0] buf_data;
    logic [3:0]            buf_len;
    logic [2:0]            buf_mode;
    logic                  buf_two_stop;
    logic                  load;

    tx_state_e             state, state_nxt;
    logic [MAX_DATA_W-1:0] shifter, shift_nxt;
    logic [CNT_W-1:0]      bit_cnt, cnt_nxt;
    logic [CNT_W-1:0]      len_last_q, len_last_nxt;
    logic                  stop_cnt, stop_nxt;
    logic                  par_en_q, par_en_nxt;
    logic                  par_bit_q, par_bit_nxt;
    logic                  two_stop_q, two_nxt;
    logic                  tx_q, tx_nxt;

    logic [MAX_DATA_W-1:0] src_data;
    logic [3:0]            src_len;
    logic [2:0]            src_mode;
    logic                  src_two;
    logic [3:0]            len_cl;
    logic [MAX_DATA_W-1:0] mask;
    logic [MAX_DATA_W-1:0] masked;
    logic                  src_par_en;
    logic                  src_par_bit;

    uart_tx_holdbuf #(.W(MAX_DATA_W)) u_holdbuf (
        .baud_clk      (baud_clk),
        .rst_n         (rst_n),
        .data          (tx_data),
        .len           (data_len),
        .mode          (parity_mode),
        .two_stop      (two_stop),
        .valid         (tx_valid),
        .take          (load),
        .ready         (tx_ready),
        .full          (buf_full),
        .held_data     (buf_data),
        .held_len      (buf_len),
        .held_mode     (buf_mode),
        .held_two_stop (buf_two_stop)
    );

    assign tx   = tx_q;
    assign busy = (state != IDLE);
    assign done = (state == STOP) && (stop_cnt == two_stop_q);

    // Frame source: the held word, or the word being handed over right now
    // when the buffer is empty at the last stop bit.
    always_comb begin
        src_data = buf_full ? buf_data     : tx_data;
        src_len  = buf_full ? buf_len      : data_len;
        src_mode = buf_full ? buf_mode     : parity_mode;
        src_two  = buf_full ? buf_two_stop : two_stop;
        len_cl   = clamp_len(src_len, MAX_DATA_W);
        mask     = '0;
        for (int unsigned i = 0; i < MAX_DATA_W; i++)
            mask[i] = (i < 32'(len_cl));
        masked      = src_data & mask;
        src_par_en  = 1'b1;
        src_par_bit = 1'b0;
        case (src_mode)
            PAR_EVEN:  src_par_bit = ^masked;
            PAR_ODD:   src_par_bit = ~(^masked);
            PAR_MARK:  src_par_bit = 1'b1;
            PAR_SPACE: src_par_bit = 1'b0;
            default:   src_par_en  = 1'b0;
        endcase
    end

    // Next-state, shifter, counters and the next serial bit.
    always_comb begin
        state_nxt    = state;
        shift_nxt    = shifter;
        cnt_nxt      = bit_cnt;
        stop_nxt     = stop_cnt;
        len_last_nxt = len_last_q;
        par_en_nxt   = par_en_q;
        par_bit_nxt  = par_bit_q;
        two_nxt      = two_stop_q;
        load         = 1'b0;
        tx_nxt       = 1'b1;

        case (state)
            IDLE: begin
                if (buf_full) load = 1'b1;
            end
            START: begin
                state_nxt = DATA;
                cnt_nxt   = '0;
            end
            DATA: begin
                if (bit_cnt == len_last_q) begin
                    cnt_nxt   = '0;
                    stop_nxt  = 1'b0;
                    state_nxt = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_nxt   = bit_cnt + 1'b1;
                    shift_nxt = shifter >> 1;
                end
            end
            PARITY: begin
                state_nxt = STOP;
                stop_nxt  = 1'b0;
            end
            STOP: begin
                if (stop_cnt == two_stop_q) begin
                    if (buf_full || tx_valid) load = 1'b1;
                    else                      state_nxt = IDLE;
                end else begin
                    stop_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            state_nxt    = START;
            shift_nxt    = masked;
            len_last_nxt = CNT_W'(len_cl - 4'd1);
            par_en_nxt   = src_par_en;
            par_bit_nxt  = src_par_bit;
            two_nxt      = src_two;
            cnt_nxt      = '0;
            stop_nxt     = 1'b0;
        end

        // tx is a flop, so it is driven from the state being entered.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = par_bit_nxt;
            default: tx_nxt = 1'b1;
        endcase
    end

    // State, datapath and line registers; reset forces the line idle at once.
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shifter    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            len_last_q <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state      <= state_nxt;
            shifter    <= shift_nxt;
            bit_cnt    <= cnt_nxt;
            stop_cnt   <= stop_nxt;
            len_last_q <= len_last_nxt;
            par_en_q   <= par_en_nxt;
            par_bit_q  <= par_bit_nxt;
            two_stop_q <= two_nxt;
            tx_q       <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: frame table plus back-to-back and reset sequences.
module tb_uart_tx_framer;

    logic       baud_clk = 1'b0;
    logic       rst_n    = 1'b0;
    logic [8:0] tx_data  = '0;
    logic [3:0] data_len = 4'd8;
    logic [2:0] parity_mode = 3'd0;
    logic       two_stop = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [8:0]  data;
        logic [3:0]  len;
        logic [2:0]  mode;
        logic        two;
        int          n;
        logic [0:12] bits;
    } vec_t;

    vec_t vecs[11];

    uart_tx_framer #(.MAX_DATA_W(9)) dut (
        .baud_clk    (baud_clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .data_len    (data_len),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    always #5 baud_clk = ~baud_clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present a word at a falling edge and hold it until a rising edge accepts it.
    task automatic send(input logic [8:0] d, input logic [3:0] l, input logic [2:0] m, input logic ts);
        bit ok = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge baud_clk);
            tx_data = d; data_len = l; parity_mode = m; two_stop = ts; tx_valid = 1'b1;
            if (tx_ready) ok = 1;
        end
        if (!ok) chk("send_timeout", 16'd0, 16'd1);
        @(posedge baud_clk);
        #1;
        tx_valid    = 1'b0;
        tx_data     = ~d;
        data_len    = 4'd5;
        parity_mode = 3'd1;
        two_stop    = ~ts;
    endtask

    // Called just after the transfer edge: check every frame cycle and the idle after it.
    task automatic check_frame(input string name, input int n, input logic [0:12] bits);
        @(posedge baud_clk);
        for (int i = 0; i < n; i++) begin
            @(negedge baud_clk);
            chk({name, "_tx"},   16'(tx),   16'(bits[i]));
            chk({name, "_busy"}, 16'(busy), 16'd1);
            chk({name, "_done"}, 16'(done), 16'(i == n - 1));
        end
        @(negedge baud_clk);
        chk({name, "_idle_tx"},   16'(tx),   16'd1);
        chk({name, "_idle_busy"}, 16'(busy), 16'd0);
        chk({name, "_idle_done"}, 16'(done), 16'd0);
    endtask

    initial begin
        logic [0:19] b2b;

        vecs[0]  = '{9'h0A5, 4'd8,  3'd0, 1'b0, 10, 13'b0101001011_000};
        vecs[1]  = '{9'h013, 4'd5,  3'd1, 1'b0,  8, 13'b01100111_00000};
        vecs[2]  = '{9'h013, 4'd5,  3'd2, 1'b0,  8, 13'b01100101_00000};
        vecs[3]  = '{9'h013, 4'd5,  3'd3, 1'b0,  8, 13'b01100111_00000};
        vecs[4]  = '{9'h013, 4'd5,  3'd4, 1'b0,  8, 13'b01100101_00000};
        vecs[5]  = '{9'h013, 4'd5,  3'd5, 1'b0,  7, 13'b0110011_000000};
        vecs[6]  = '{9'h013, 4'd5,  3'd7, 1'b0,  7, 13'b0110011_000000};
        vecs[7]  = '{9'h1FF, 4'd9,  3'd1, 1'b1, 13, 13'b0111111111111};
        vecs[8]  = '{9'h1F3, 4'd3,  3'd1, 1'b0,  8, 13'b01100111_00000};
        vecs[9]  = '{9'h0AB, 4'd15, 3'd0, 1'b0, 11, 13'b01101010101_00};
        vecs[10] = '{9'h05A, 4'd7,  3'd2, 1'b1, 11, 13'b00101101111_00};

        // Reset state
        #12;
        chk("rst_tx",    16'(tx),       16'd1);
        chk("rst_busy",  16'(busy),     16'd0);
        chk("rst_done",  16'(done),     16'd0);
        chk("rst_ready", 16'(tx_ready), 16'd1);
        @(negedge baud_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge baud_clk);

        // Table of single frames; inputs are scrambled right after each transfer
        for (int v = 0; v < 11; v++) begin
            send(vecs[v].data, vecs[v].len, vecs[v].mode, vecs[v].two);
            check_frame($sformatf("vec%0d", v), vecs[v].n, vecs[v].bits);
        end

        // Back-to-back 0x55 then 0x0F with tx_valid held high
        b2b = 20'b0101010101_0111100001;
        @(negedge baud_clk);
        chk("b2b_ready0", 16'(tx_ready), 16'd1);
        tx_data = 9'h055; data_len = 4'd8; parity_mode = 3'd0; two_stop = 1'b0; tx_valid = 1'b1;
        @(posedge baud_clk);
        #1 tx_data = 9'h00F;
        @(posedge baud_clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge baud_clk);
            chk("b2b_tx",   16'(tx),   16'(b2b[i]));
            chk("b2b_busy", 16'(busy), 16'd1);
            chk("b2b_done", 16'(done), 16'(i == 9 || i == 19));
            if (i == 1 || i == 5) chk("b2b_ready_low", 16'(tx_ready), 16'd0);
            if (i == 0) begin
                @(posedge baud_clk);
                #1 tx_valid = 1'b0; tx_data = 9'h1AA; data_len = 4'd5;
            end
        end
        @(negedge baud_clk);
        chk("b2b_end_busy", 16'(busy), 16'd0);
        chk("b2b_end_tx",   16'(tx),   16'd1);

        // Reset during DATA with a second word buffered
        send(9'h0A5, 4'd8, 3'd0, 1'b0);
        send(9'h033, 4'd8, 3'd0, 1'b0);
        @(negedge baud_clk);
        chk("mid_d0", 16'(tx), 16'd1);
        @(negedge baud_clk);
        chk("mid_d1",    16'(tx),       16'd0);
        chk("mid_full",  16'(tx_ready), 16'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx",    16'(tx),       16'd1);
        chk("mid_rst_busy",  16'(busy),     16'd0);
        chk("mid_rst_ready", 16'(tx_ready), 16'd1);
        chk("mid_rst_done",  16'(done),     16'd0);
        @(negedge baud_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge baud_clk);
            chk("post_rst_tx",   16'(tx),   16'd1);
            chk("post_rst_busy", 16'(busy), 16'd0);
            chk("post_rst_done", 16'(done), 16'd0);
        end

        // Line works again after reset
        send(vecs[0].data, vecs[0].len, vecs[0].mode, vecs[0].two);
        check_frame("after_rst", vecs[0].n, vecs[0].bits);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
